// File: rtl/serial_alu.sv
// serial_alu: multi-cycle ALU that processes a WIDTH-bit operation SLICE bits
// per clock, LSB first, through one shared SLICE-bit adder/logic slice.
// The carry is held in a register between slices.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high; aborts any operation in flight
//   start    - request a new operation (sampled only while idle)
//   op       - 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
//   a, b     - operands, captured when start is accepted
//   busy     - high while an operation is in flight
//   done     - one-cycle pulse; result and flags are valid from this cycle on
//   result   - registered result, held until the next done or reset
//   carryout - registered carry out of the MSB (ADD/SUB only)
//   overflow - registered signed overflow (ADD/SUB only)
//   zero     - high when result equals 0
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_SLT  = 3'd3,
    OP_AND  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_OR   = 3'd7
  } op_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nx;

  // Operand copies shift right by SLICE each compute cycle, so the slice
  // being processed is always in the low bits.
  logic [WIDTH-1:0] a_sh, b_sh, shadow;
  op_t              op_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last;

  logic [SLICE-1:0] sa, sb, sb_eff, slice_res;
  logic [SLICE:0]   sum;
  logic             is_sub, msb_cin, slt_bit;
  logic [WIDTH-1:0] shadow_nx, final_res;
  logic             fin_cout, fin_ovf;

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sa        = a_sh[SLICE-1:0];
    sb        = b_sh[SLICE-1:0];
    is_sub    = (op_q == OP_SUB) || (op_q == OP_SLT);
    sb_eff    = is_sub ? ~sb : sb;
    sum       = {1'b0, sa} + {1'b0, sb_eff} + {{SLICE{1'b0}}, carry};
    // Carry into the top bit of this slice; only meaningful on the last slice,
    // where it is the carry into the MSB of the whole word.
    msb_cin   = sa[SLICE-1] ^ sb_eff[SLICE-1] ^ sum[SLICE-1];
    slt_bit   = sum[SLICE-1] ^ (msb_cin ^ sum[SLICE]);

    case (op_q)
      OP_ADD, OP_SUB, OP_SLT: slice_res = sum[SLICE-1:0];
      OP_XOR:                 slice_res = sa ^ sb;
      OP_AND:                 slice_res = sa & sb;
      OP_NAND:                slice_res = ~(sa & sb);
      OP_NOR:                 slice_res = ~(sa | sb);
      OP_OR:                  slice_res = sa | sb;
      default:                slice_res = '0;
    endcase

    // New slice enters at the top; after N shifts slice 0 sits at the bottom.
    shadow_nx = shadow >> SLICE;
    shadow_nx[WIDTH-1 -: SLICE] = slice_res;

    final_res = shadow_nx;
    fin_cout  = 1'b0;
    fin_ovf   = 1'b0;
    if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
      fin_cout = sum[SLICE];
      fin_ovf  = msb_cin ^ sum[SLICE];
    end else if (op_q == OP_SLT) begin
      final_res = WIDTH'(slt_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      shadow   <= '0;
      op_q     <= OP_ADD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op_t'(op);
            cnt   <= '0;
            carry <= (op_t'(op) == OP_SUB) || (op_t'(op) == OP_SLT);
          end
        end
        RUN: begin
          a_sh   <= a_sh >> SLICE;
          b_sh   <= b_sh >> SLICE;
          shadow <= shadow_nx;
          carry  <= sum[SLICE];
          cnt    <= cnt + CW'(1);
          if (last) begin
            result   <= final_res;
            carryout <= fin_cout;
            overflow <= fin_ovf;
            zero     <= (final_res == '0);
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: self-checking bench for serial_alu. Two instances run side by
// side: index 0 with SLICE=1 (32 compute cycles), index 1 with SLICE=4 (8).
// A transaction-level model predicts busy/done/result/flags every cycle.
module tb_serial_alu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        start [2];
  logic [2:0]  op    [2];
  logic [31:0] a     [2];
  logic [31:0] b     [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] res   [2];
  logic        cout  [2];
  logic        ovf   [2];
  logic        zero  [2];

  int checks = 0;
  int errors = 0;
  int done_cnt [2];

  serial_alu #(.WIDTH(32), .SLICE(1)) dut_s1 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .op(op[0]), .a(a[0]), .b(b[0]),
    .busy(busy[0]), .done(done[0]), .result(res[0]), .carryout(cout[0]),
    .overflow(ovf[0]), .zero(zero[0])
  );

  serial_alu #(.WIDTH(32), .SLICE(4)) dut_s4 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .op(op[1]), .a(a[1]), .b(b[1]),
    .busy(busy[1]), .done(done[1]), .result(res[1]), .carryout(cout[1]),
    .overflow(ovf[1]), .zero(zero[1])
  );

  function automatic int ncyc(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  typedef struct packed {
    logic        z;
    logic        v;
    logic        c;
    logic [31:0] r;
  } ref_t;

  // Whole-word reference: plain 33-bit arithmetic and signed compare.
  function automatic ref_t ref_alu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    ref_t        t;
    logic [32:0] s;
    t = '0;
    case (o)
      3'd0: begin
        s   = {1'b0, x} + {1'b0, y};
        t.r = s[31:0];
        t.c = s[32];
        t.v = (x[31] == y[31]) && (t.r[31] != x[31]);
      end
      3'd1: begin
        s   = {1'b0, x} + {1'b0, ~y} + 33'd1;
        t.r = s[31:0];
        t.c = s[32];
        t.v = (x[31] != y[31]) && (t.r[31] != x[31]);
      end
      3'd2: t.r = x ^ y;
      3'd3: t.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd4: t.r = x & y;
      3'd5: t.r = ~(x & y);
      3'd6: t.r = ~(x | y);
      default: t.r = x | y;
    endcase
    t.z = (t.r == 32'd0);
    return t;
  endfunction

  // Model state
  int          m_rem  [2] = '{0, 0};
  logic        m_busy [2] = '{1'b0, 1'b0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic [31:0] m_res  [2] = '{32'd0, 32'd0};
  logic        m_c    [2] = '{1'b0, 1'b0};
  logic        m_v    [2] = '{1'b0, 1'b0};
  logic        m_z    [2] = '{1'b1, 1'b1};
  logic [2:0]  m_op   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_rem[i]  = 0;
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_res[i]  = 32'd0;
        m_c[i]    = 1'b0;
        m_v[i]    = 1'b0;
        m_z[i]    = 1'b1;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            ref_t t;
            t = ref_alu(m_op[i], m_a[i], m_b[i]);
            m_res[i]  = t.r;
            m_c[i]    = t.c;
            m_v[i]    = t.v;
            m_z[i]    = t.z;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end else if (start[i]) begin
          m_op[i]   = op[i];
          m_a[i]    = a[i];
          m_b[i]    = b[i];
          m_busy[i] = 1'b1;
          m_rem[i]  = ncyc(i);
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, i, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("busy",     i, 32'(busy[i]), 32'(m_busy[i]));
      chk("done",     i, 32'(done[i]), 32'(m_done[i]));
      chk("result",   i, res[i],       m_res[i]);
      chk("carryout", i, 32'(cout[i]), 32'(m_c[i]));
      chk("overflow", i, 32'(ovf[i]),  32'(m_v[i]));
      chk("zero",     i, 32'(zero[i]), 32'(m_z[i]));
      if (done[i] === 1'b1) done_cnt[i]++;
    end
  end

  // Starts one operation, optionally pulses a stray start mid-flight, and waits
  // for done. lat counts edges from the accept edge to the done edge inclusive.
  task automatic issue(input int i, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit junk, output int lat, output int bcyc);
    int g;
    g = 0;
    while (busy[i] !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    op[i] = o; a[i] = x; b[i] = y; start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    lat  = 1;
    bcyc = (busy[i] === 1'b1) ? 1 : 0;
    while (done[i] !== 1'b1 && lat < 200) begin
      if (junk && lat == 3) begin
        op[i] = 3'd7; a[i] = 32'd0; b[i] = 32'd0; start[i] = 1'b1;
      end else begin
        start[i] = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (busy[i] === 1'b1) bcyc++;
    end
    start[i] = 1'b0;
    if (done[i] !== 1'b1) chk("done_timeout", i, 32'(done[i]), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_ops(input int i, input int count);
    int lat, bcyc;
    for (int k = 0; k < count; k++) begin
      issue(i, 3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0), lat, bcyc);
      chk("latency", i, 32'(lat), 32'(ncyc(i) + 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic        c;
    logic        v;
    bit          j;
  } dt_t;

  dt_t tbl [7] = '{
    '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
    '{3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0},
    '{3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0},
    '{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
    '{3'd3, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
    '{3'd3, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0},
    '{3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcyc, lat2, dc;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; op[i] = 3'd0; a[i] = 32'd0; b[i] = 32'd0;
      done_cnt[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_result", 0, res[0], 32'd0);
    chk("reset_zero",   0, 32'(zero[0]), 32'd1);
    chk("reset_busy",   1, 32'(busy[1]), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Directed cases on the bit-serial instance
    for (int k = 0; k < 7; k++) begin
      issue(0, tbl[k].o, tbl[k].x, tbl[k].y, tbl[k].j, lat, bcyc);
      chk("dir_latency",  0, 32'(lat),     32'd33);
      chk("dir_busycyc",  0, 32'(bcyc),    32'd32);
      chk("dir_result",   0, res[0],       tbl[k].r);
      chk("dir_carryout", 0, 32'(cout[0]), 32'(tbl[k].c));
      chk("dir_overflow", 0, 32'(ovf[0]),  32'(tbl[k].v));
      chk("dir_zero",     0, 32'(zero[0]), 32'(tbl[k].r == 32'd0));
    end

    // Reset at the 10th compute edge aborts the operation
    op[0] = 3'd0; a[0] = 32'd1; b[0] = 32'd1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("abort_busy",   0, 32'(busy[0]), 32'd0);
    chk("abort_done",   0, 32'(done[0]), 32'd0);
    chk("abort_result", 0, res[0],       32'd0);
    chk("abort_zero",   0, 32'(zero[0]), 32'd1);
    dc = done_cnt[0];
    repeat (40) @(negedge clk);
    chk("abort_no_done", 0, 32'(done_cnt[0]), 32'(dc));
    issue(0, 3'd0, 32'd2, 32'd3, 1'b0, lat, bcyc);
    chk("after_abort_add", 0, res[0], 32'd5);

    // Back-to-back on the 4-bit-slice instance with start held high
    op[1] = 3'd0; a[1] = 32'hFFFF_FFFF; b[1] = 32'd1; start[1] = 1'b1;
    @(negedge clk);
    op[1] = 3'd2; a[1] = 32'hAAAA_AAAA; b[1] = 32'h5555_5555;
    lat = 1;
    while (done[1] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat1",  1, 32'(lat),     32'd9);
    chk("b2b_res1",  1, res[1],       32'd0);
    chk("b2b_cout1", 1, 32'(cout[1]), 32'd1);
    chk("b2b_zero1", 1, 32'(zero[1]), 32'd1);
    @(negedge clk);
    lat2 = 1;
    while (done[1] !== 1'b1 && lat2 < 100) begin
      @(negedge clk);
      lat2++;
    end
    start[1] = 1'b0;
    chk("b2b_spacing", 1, 32'(lat2),    32'd9);
    chk("b2b_res2",    1, res[1],       32'hFFFF_FFFF);
    chk("b2b_cout2",   1, 32'(cout[1]), 32'd0);
    chk("b2b_zero2",   1, 32'(zero[1]), 32'd0);

    // Randomized traffic on both instances
    fork
      rand_ops(0, 25);
      rand_ops(1, 60);
    join

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
